// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: main control FSM for a multicycle MIPS-subset core.
// Sequences FETCH/DECODE/EXEC/MEM/WB per instruction, emits datapath enables,
// a one-cycle retire pulse and a free-running retired-instruction counter.
// Optional feature: define MC_CTRL_BREAK_HALT_EN to make `break` stop the core
// in HALT until reset; without it `break` is an unrecognised funct.
module mc_ctrl_fsm (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  op,
    input  logic [5:0]  funct,
    input  logic        overflow,
    input  logic        zero,
    input  logic        dm_ready,
    output logic        pc_we,
    output logic        ir_we,
    output logic        rf_we,
    output logic        dm_cs,
    output logic        dm_r,
    output logic        dm_w,
    output logic        branch_take,
    output logic [2:0]  state,
    output logic        instr_done,
    output logic [31:0] retired,
    output logic        halted
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] F_JR     = 6'h08;
    localparam logic [5:0] F_BREAK  = 6'h0D;
    localparam logic [5:0] F_ADD    = 6'h20;
    localparam logic [5:0] F_SUB    = 6'h22;

    // R-type functs that execute on the ALU and write back (shifts and ALU ops)
    function automatic logic r_alu_funct(input logic [5:0] f);
        case (f)
            6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
            6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
            6'h26, 6'h27, 6'h2A, 6'h2B: r_alu_funct = 1'b1;
            default:                     r_alu_funct = 1'b0;
        endcase
    endfunction

    // Immediate ALU opcodes addi..lui occupy the contiguous range 0x08..0x0F
    function automatic logic i_alu_op(input logic [5:0] o);
        i_alu_op = (o[5:3] == 3'b001);
    endfunction

    state_t state_q;
    state_t state_d;

    logic is_rtype;
    logic is_jump;
    logic is_jal;
    logic is_beq;
    logic is_bne;
    logic is_lw;
    logic is_sw;
    logic is_alu;
    logic ovf_trap;
`ifdef MC_CTRL_BREAK_HALT_EN
    logic is_break;
`endif

    // Instruction class decode from the held IR fields
    always_comb begin
        is_rtype = (op == OP_RTYPE);
        is_jump  = (op == OP_J) || (is_rtype && (funct == F_JR));
        is_jal   = (op == OP_JAL);
        is_beq   = (op == OP_BEQ);
        is_bne   = (op == OP_BNE);
        is_lw    = (op == OP_LW);
        is_sw    = (op == OP_SW);
        is_alu   = (is_rtype && r_alu_funct(funct)) || i_alu_op(op);
        // Trapping adds suppress the register write but still retire
        ovf_trap = overflow &&
                   ((is_rtype && ((funct == F_ADD) || (funct == F_SUB))) ||
                    (op == OP_ADDI));
`ifdef MC_CTRL_BREAK_HALT_EN
        is_break = is_rtype && (funct == F_BREAK);
`endif
    end

    // Next-state and control outputs; reset masks every enable
    always_comb begin
        state_d     = state_q;
        pc_we       = 1'b0;
        ir_we       = 1'b0;
        rf_we       = 1'b0;
        dm_cs       = 1'b0;
        dm_r        = 1'b0;
        dm_w        = 1'b0;
        branch_take = 1'b0;
        instr_done  = 1'b0;

        case (state_q)
            S_FETCH: begin
                ir_we   = 1'b1;
                pc_we   = 1'b1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                if (is_jump) begin
                    pc_we      = 1'b1;
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end else if (is_jal) begin
                    pc_we   = 1'b1;
                    state_d = S_WB;
`ifdef MC_CTRL_BREAK_HALT_EN
                end else if (is_break) begin
                    instr_done = 1'b1;
                    state_d    = S_HALT;
`endif
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (is_beq || is_bne) begin
                    branch_take = (is_beq && zero) || (is_bne && !zero);
                    pc_we       = branch_take;
                    instr_done  = 1'b1;
                    state_d     = S_FETCH;
                end else if (is_lw || is_sw) begin
                    state_d = S_MEM;
                end else if (is_alu) begin
                    state_d = S_WB;
                end else begin
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end
            end
            S_MEM: begin
                dm_cs = 1'b1;
                dm_r  = is_lw;
                dm_w  = is_sw;
                if (dm_ready) begin
                    if (is_lw) begin
                        state_d = S_WB;
                    end else begin
                        instr_done = 1'b1;
                        state_d    = S_FETCH;
                    end
                end
            end
            S_WB: begin
                rf_we      = !ovf_trap;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_HALT: begin
`ifdef MC_CTRL_BREAK_HALT_EN
                state_d = S_HALT;
`else
                state_d = S_FETCH;
`endif
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        if (rst) begin
            pc_we       = 1'b0;
            ir_we       = 1'b0;
            rf_we       = 1'b0;
            dm_cs       = 1'b0;
            dm_r        = 1'b0;
            dm_w        = 1'b0;
            branch_take = 1'b0;
            instr_done  = 1'b0;
        end
    end

    // State register and retired-instruction counter (wraps naturally)
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            retired <= 32'd0;
        end else begin
            state_q <= state_d;
            if (instr_done) begin
                retired <= retired + 32'd1;
            end
        end
    end

    assign state = state_q;

`ifdef MC_CTRL_BREAK_HALT_EN
    assign halted = (state_q == S_HALT);
`else
    assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb_mc_ctrl_fsm: directed and randomized check of mc_ctrl_fsm against an
// instruction-level reference model (class -> expected phase sequence).
module tb_mc_ctrl_fsm;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        overflow;
    logic        zero;
    logic        dm_ready;
    logic        pc_we;
    logic        ir_we;
    logic        rf_we;
    logic        dm_cs;
    logic        dm_r;
    logic        dm_w;
    logic        branch_take;
    logic [2:0]  state;
    logic        instr_done;
    logic [31:0] retired;
    logic        halted;

    mc_ctrl_fsm dut (
        .clk(clk), .rst(rst), .op(op), .funct(funct), .overflow(overflow),
        .zero(zero), .dm_ready(dm_ready), .pc_we(pc_we), .ir_we(ir_we),
        .rf_we(rf_we), .dm_cs(dm_cs), .dm_r(dm_r), .dm_w(dm_w),
        .branch_take(branch_take), .state(state), .instr_done(instr_done),
        .retired(retired), .halted(halted)
    );

    always #5 clk = ~clk;

    typedef enum int {K_J, K_JAL, K_BR, K_ALU, K_LW, K_SW, K_BAD, K_BRK} kind_t;
    typedef enum int {P_F, P_D, P_E, P_M, P_W, P_H} phase_t;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_retired;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // Instruction class straight from the supported-instruction list
    function automatic kind_t classify(input logic [5:0] o, input logic [5:0] f);
        if (o == 6'h00) begin
            if (f == 6'h08) return K_J;
`ifdef MC_CTRL_BREAK_HALT_EN
            if (f == 6'h0D) return K_BRK;
`endif
            if (f inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h20, 6'h21,
                          6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B})
                return K_ALU;
            return K_BAD;
        end
        if (o == 6'h02) return K_J;
        if (o == 6'h03) return K_JAL;
        if (o == 6'h04 || o == 6'h05) return K_BR;
        if (o == 6'h23) return K_LW;
        if (o == 6'h2B) return K_SW;
        if (o >= 6'h08 && o <= 6'h0F) return K_ALU;
        return K_BAD;
    endfunction

    function automatic logic [31:0] obs_vec();
        return {20'd0, state, halted, pc_we, ir_we, rf_we, dm_cs, dm_r, dm_w,
                branch_take, instr_done};
    endfunction

    // Run one instruction; mode 0/1 force the flag, 2 randomizes it per cycle.
    // abort_at >= 0 pulses rst in that cycle; halt_hold = HALT cycles observed.
    task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input int w,
                             input int ovf_mode, input int zero_mode,
                             input int abort_at, input int halt_hold);
        kind_t       k;
        phase_t      ph[$];
        int          mem_i;
        logic [2:0]  st;
        logic        pcw, irw, rfw, cs, rd, wr, bt, dn, hl;
        logic [31:0] ev;
        k = classify(o, f);
        ph.push_back(P_F);
        ph.push_back(P_D);
        case (k)
            K_JAL: ph.push_back(P_W);
            K_BR, K_BAD: ph.push_back(P_E);
            K_ALU: begin ph.push_back(P_E); ph.push_back(P_W); end
            K_LW, K_SW: begin
                ph.push_back(P_E);
                for (int m = 0; m <= w; m++) ph.push_back(P_M);
                if (k == K_LW) ph.push_back(P_W);
            end
            K_BRK: for (int h = 0; h < halt_hold; h++) ph.push_back(P_H);
            default: ;
        endcase
        op = o;
        funct = f;
        mem_i = 0;
        for (int i = 0; i < ph.size(); i++) begin
            overflow = (ovf_mode == 2) ? 1'($urandom_range(0, 1)) : 1'(ovf_mode);
            zero     = (zero_mode == 2) ? 1'($urandom_range(0, 1)) : 1'(zero_mode);
            dm_ready = (ph[i] == P_M) ? (mem_i == w) : 1'($urandom_range(0, 1));
            rst      = (i == abort_at);
            @(negedge clk);
            st = 3'd0; pcw = 0; irw = 0; rfw = 0; cs = 0; rd = 0; wr = 0;
            bt = 0; dn = 0; hl = 0;
            case (ph[i])
                P_F: begin st = 3'd0; irw = 1; pcw = 1; end
                P_D: begin
                    st = 3'd1;
                    if (k == K_J) begin pcw = 1; dn = 1; end
                    else if (k == K_JAL) pcw = 1;
                    else if (k == K_BRK) dn = 1;
                end
                P_E: begin
                    st = 3'd2;
                    if (k == K_BR) begin
                        bt = (o == 6'h04) ? zero : !zero;
                        pcw = bt;
                        dn = 1;
                    end else if (k == K_BAD) dn = 1;
                end
                P_M: begin
                    st = 3'd3; cs = 1; rd = (k == K_LW); wr = (k == K_SW);
                    dn = (k == K_SW) && dm_ready;
                end
                P_W: begin
                    st = 3'd4; dn = 1;
                    rfw = !(overflow && (o == 6'h08 ||
                            (o == 6'h00 && (f == 6'h20 || f == 6'h22))));
                end
                P_H: begin st = 3'd5; hl = 1; end
                default: ;
            endcase
            if (rst) begin
                pcw = 0; irw = 0; rfw = 0; cs = 0; rd = 0; wr = 0; bt = 0; dn = 0;
            end
            ev = {20'd0, st, hl, pcw, irw, rfw, cs, rd, wr, bt, dn};
            chk($sformatf("op%0h/f%0h c%0d ctl", o, f, i), obs_vec(), ev);
            @(posedge clk);
            #1;
            if (rst) begin
                rst = 1'b0;
                exp_retired = 32'd0;
                chk("state after rst", {29'd0, state}, 32'd0);
                chk("retired after rst", retired, exp_retired);
                return;
            end
            if (dn) exp_retired = exp_retired + 32'd1;
            if (ph[i] == P_M) mem_i++;
        end
        if (k == K_BRK) begin
            chk("retired at halt", retired, exp_retired);
            rst = 1'b1;
            @(negedge clk);
            chk("halt under rst", obs_vec(), {20'd0, 3'd5, 1'b1, 8'd0});
            @(posedge clk);
            #1;
            rst = 1'b0;
            exp_retired = 32'd0;
            chk("state after halt rst", {28'd0, halted, state}, 32'd0);
        end
        chk($sformatf("op%0h/f%0h retired", o, f), retired, exp_retired);
    endtask

    logic [11:0] pool [16];

    initial begin
        logic [11:0] ent;
        logic [5:0]  ro;
        logic [5:0]  rf;
        pool = '{12'h021, 12'h020, 12'h022, 12'h000, 12'h02A, 12'h008,
                 12'h00D, 12'h001, 12'h080, 12'h0C0, 12'h100, 12'h140,
                 12'h200, 12'h3C0, 12'h8C0, 12'hAC0};
        rst = 1'b1; op = 6'd0; funct = 6'd0; overflow = 1'b0; zero = 1'b0;
        dm_ready = 1'b1;
        exp_retired = 32'd0;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("reset ctl", obs_vec(), 32'd0);
        chk("reset retired", retired, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        run_instr(6'h00, 6'h21, 0, 0, 2, -1, 0);   // addu, no overflow
        run_instr(6'h00, 6'h20, 0, 1, 2, -1, 0);   // add, overflow suppresses write
        run_instr(6'h08, 6'h00, 0, 1, 2, -1, 0);   // addi, overflow
        run_instr(6'h23, 6'h00, 3, 2, 2, -1, 0);   // lw, 3 wait cycles
        run_instr(6'h04, 6'h00, 0, 2, 1, -1, 0);   // beq taken
        run_instr(6'h05, 6'h00, 0, 2, 1, -1, 0);   // bne not taken
        run_instr(6'h02, 6'h00, 0, 2, 2, -1, 0);   // j
        run_instr(6'h00, 6'h08, 0, 2, 2, -1, 0);   // jr
        run_instr(6'h03, 6'h00, 0, 1, 2, -1, 0);   // jal writes $31 regardless
        run_instr(6'h2B, 6'h00, 0, 2, 2, -1, 0);   // sw, no wait
        run_instr(6'h3F, 6'h00, 0, 2, 2, -1, 0);   // unrecognised op
        run_instr(6'h00, 6'h0D, 0, 2, 2, -1, 10);  // break
        run_instr(6'h00, 6'h21, 0, 0, 2, -1, 0);
        run_instr(6'h2B, 6'h00, 4, 2, 2, 4, 0);    // rst in second MEM wait of sw
        run_instr(6'h0F, 6'h00, 0, 2, 2, -1, 0);   // lui after reset

        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                ro = 6'($urandom);
                rf = 6'($urandom);
            end else begin
                ent = pool[$urandom_range(0, 15)];
                ro = ent[11:6];
                rf = ent[5:0];
            end
            run_instr(ro, rf, int'($urandom_range(0, 4)), 2, 2,
                      ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 5)) : -1, 3);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mc_ctrl_fsm.md
MC_CTRL_FSM -- requirements
Module: mc_ctrl_fsm

Interface
REQ-001 The block SHALL use one clock and a synchronous active-high reset: clk samples all state, and rst is sampled only on rising clk.
REQ-002 The block SHALL have these ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- op  in  6  IR[31:26], stable from the cycle after FETCH
- funct  in  6  IR[5:0]
- overflow  in  1  ALU signed overflow, valid in EXEC and WB
- zero  in  1  ALU zero flag, valid in EXEC
- dm_ready  in  1  data-memory access complete
- pc_we  out  1  PC write enable
- ir_we  out  1  IR write enable
- rf_we  out  1  register-file write enable
- dm_cs  out  1  data-memory chip select
- dm_r  out  1  data-memory read
- dm_w  out  1  data-memory write
- branch_take  out  1  selects the branch target into PC
- state  out  3  current state code
- instr_done  out  1  one-cycle retire pulse
- retired  out  32  count of retired instructions
- halted  out  1  core stopped

Function
REQ-003 States SHALL be encoded FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5; codes 6 and 7 SHALL go to FETCH on the next edge with all enables 0.
REQ-004 Only the state register and retired SHALL be registered; all other outputs SHALL be combinational in state, op, funct, overflow, zero and dm_ready.
REQ-005 FETCH: ir_we=1 and pc_we=1 (PC+4); next state DECODE.
REQ-006 DECODE, for j or jr: pc_we=1 and instr_done=1; next state FETCH.
REQ-007 DECODE, for jal: pc_we=1; next state WB, where $31 is written.
REQ-008 DECODE, for all other opcodes: next state EXEC.
REQ-009 EXEC, for beq/bne: branch_take=(beq&zero)|(bne&!zero); pc_we=branch_take; instr_done=1; next state FETCH.
REQ-010 EXEC, for lw/sw: next state MEM.
REQ-011 EXEC, for R-type ALU, shift, addi/addiu/andi/ori/xori/slti/sltiu/lui: next state WB.
REQ-012 EXEC, for an unrecognised op or funct: no writes; instr_done=1; next state FETCH.
REQ-013 MEM: dm_cs=1, with dm_r=lw and dm_w=sw, held every cycle until dm_ready=1.
REQ-014 MEM, on the dm_ready=1 cycle: lw goes to WB; sw asserts instr_done and goes to FETCH.
REQ-015 MEM: dm_ready sampled in any other state SHALL be ignored.
REQ-016 WB: rf_we=1 except when (add|sub|addi)&overflow, which gives rf_we=0 while the instruction still retires; instr_done=1; next state FETCH.
REQ-017 Latency from FETCH entry to the instr_done cycle:
- j/jr: 2 cycles
- beq/bne and jal: 3 cycles
- ALU ops: 4 cycles
- sw: 4+W cycles
- lw: 5+W cycles
- W = number of MEM cycles with dm_ready=0.
REQ-018 retired SHALL increment by 1 on every edge where instr_done=1 and SHALL wrap from 0xFFFFFFFF to 0.
REQ-019 At most one of pc_we, rf_we and dm_w SHALL be asserted in any cycle, except pc_we together with ir_we in FETCH.

Reset
REQ-020 While rst=1, all enables and instr_done SHALL be forced to 0 combinationally.
REQ-021 On a rising clk with rst=1: state becomes FETCH (0), retired becomes 0, and halted becomes 0.
REQ-022 rst asserted mid-instruction (including MEM wait or HALT) SHALL abandon it without a retire pulse or counter increment.

Configuration
REQ-023 With macro MC_CTRL_BREAK_HALT_EN defined, DECODE of op=000000 with funct=001101 (break) SHALL assert instr_done and enter HALT.
REQ-024 With MC_CTRL_BREAK_HALT_EN defined, HALT SHALL be left only by reset; in HALT all enables are 0 and halted=1.
REQ-025 Without MC_CTRL_BREAK_HALT_EN, break SHALL be treated as an unrecognised funct (REQ-012), HALT SHALL be unreachable, and halted SHALL be tied 0.

Verification
REQ-026 addu (op=0, funct=0x21), overflow=0 -> state sequence 0,1,2,4,0; rf_we=1 only in WB; instr_done on cycle 4; retired=1.
REQ-027 add with overflow=1 in WB -> rf_we=0 throughout; instr_done=1; retired increments.
REQ-028 lw (op=0x23) with dm_ready low for 3 MEM cycles -> dm_cs=dm_r=1 for 4 cycles, then WB with rf_we=1; total 8 cycles.
REQ-029 beq with zero=1, then bne with zero=1 -> branch_take=pc_we=1 in the first EXEC and 0 in the second; each takes 3 cycles.
REQ-030 rst pulsed during the second MEM wait cycle of sw -> next state 0; dm_w=0; retired unchanged at 0 after reset.
REQ-031 With MC_CTRL_BREAK_HALT_EN defined, issue break then hold 10 cycles -> state=5, halted=1, no enables; rst returns state to 0.
